multi_timer: RTL and testbench
==============================

# multi_timer

Memory-mapped bank of `CHANNELS` independent prescaled interval timers on the processor data bus. It is the parametrised successor to the single-channel timer peripheral, sharing its register semantics (count, limit, control with ready/overrun/IE). Each channel adds an enable bit and an optional one-shot mode. A per-channel interrupt vector and an OR-reduced `inta_ready` feed the interrupt controller.

## Interface
- `BITS`, 32, data/address width
- `CHANNELS`, 4, number of timer channels (1..16)
- `BASE`, 32'hF0000100, byte address of channel 0; channel i occupies `BASE + 16*i`
- `TIME_LENGTH`, 1000, clk cycles per timer tick (≥1)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `we`  in  1  bus write strobe
- `re`  in  1  bus read strobe
- `memAddr`  in  BITS  bus address
- `dataBusIn`  in  BITS  write data
- `dataBusOut`  out  BITS  read data; 0 when no register is addressed
- `irq_vec`  out  CHANNELS  per-channel `ready & IE`
- `inta_ready`  out  1  OR of `irq_vec`
- `debug`  out  BITS  control register of channel 0

## Operation
- Per-channel registers: +0 CNT, +4 LIM, +8 CTRL. Offset +12 and unmapped addresses read 0; writes to them are ignored.
- CTRL bits:
  - bit0 RDY (status)
  - bit2 OVR (status)
  - bit4 ONESHOT
  - bit5 EN
  - bit8 IE
  - all other bits read 0
- A write is `we` with an address match. A read side effect requires `re & !we` with an address match.
- Prescaler: a per-channel counter of 0..TIME_LENGTH-1 runs only while EN=1. A tick occurs when it wraps.
- Count: on a tick, if CNT ≥ LIM-1, CNT←0; otherwise CNT←CNT+1.
- Terminal event: tick with CNT == LIM-1 and LIM ≠ 0. When LIM=0 the channel holds CNT=0 and produces no events.
- Terminal event behaviour:
  - RDY←1.
  - If RDY was already 1, OVR←1.
  - If ONESHOT=1, EN←0 as well.
- CNT write: CNT←(data > LIM-1) ? 0 : data. Prescaler←0.
- LIM write: LIM←data, CNT←0, prescaler←0.
- CTRL write:
  - EN, ONESHOT and IE are loaded from data.
  - Data bit2=0 clears OVR; data bit0=0 clears RDY. Writing 1 to either bit has no effect.
- CNT read returns CNT and clears RDY.
- Simultaneous events:
  - Terminal event plus CNT read in the same cycle: RDY ends at 1.
  - Terminal event plus a CTRL write clearing OVR or RDY: the set wins.
  - CNT or LIM write in the same cycle as a tick: the write wins.
- Reset: all CNT, LIM, CTRL and prescalers go to 0. Consequently `dataBusOut`=0, `irq_vec`=0, `inta_ready`=0, `debug`=0.

## Timing
- Reads are combinational: `dataBusOut` is valid in the same cycle as the address/`re`. RDY clears at the following edge.
- Writes take effect at the clk edge where `we` is sampled.
- `irq_vec` is registered. It rises the cycle after the terminal-event edge, and falls the cycle after the clearing read or write.
- From a CTRL write of EN=1 with prescaler=0, the first tick occurs TIME_LENGTH cycles later.
- Reset mid-count aborts immediately. Nothing is preserved.

## Configuration
- `MULTI_TIMER_ONESHOT_EN` defined: ONESHOT bit is implemented as described.
- Undefined: ONESHOT reads 0 and writes to it are ignored. All channels are periodic and EN is never cleared by hardware.

## Structure
- `multi_timer_pkg` holds the register offsets (CNT=0, LIM=4, CTRL=8), the CTRL bit indices, and the channel stride (16).
- Sub-module `timer_channel` holds one channel's prescaler, CNT, LIM, CTRL and event logic. Top level contains the address decode, read mux and interrupt OR.

## Test plan
- Reset, then read all registers of all channels → all 0; `inta_ready`=0.
- Ch0, TIME_LENGTH=4: LIM=3, CTRL=0x120 (EN, IE) → CNT sequence 0,1,2,0 every 4 cycles; RDY and `irq_vec[0]` rise after 12 cycles; CNT read clears both.
- Ch1, LIM=2, EN, no read over two terminal events → CTRL=0x025 (OVR, RDY, EN). CTRL write of 0x020 → 0x020.
- Ch2, with `MULTI_TIMER_ONESHOT_EN`: LIM=5, CTRL=0x130 → one terminal event, then CTRL=0x101 and CNT frozen at 0. Without the macro, same stimulus → periodic operation and CTRL reads 0x121.
- Ch3, LIM=10: write CNT=15 → reads 0; write CNT=7 → reads 7. LIM write mid-run → CNT=0.
- Terminal event coincident with a CNT read → RDY remains 1 and the read returns LIM-1.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// Shared register map for the multi_timer bank: register offsets, CTRL bit
// positions and per-channel address stride.
package multi_timer_pkg;

    localparam int OFF_CNT  = 0;
    localparam int OFF_LIM  = 4;
    localparam int OFF_CTRL = 8;

    localparam int CHANNEL_STRIDE = 16;

    localparam int CTRL_RDY     = 0;
    localparam int CTRL_OVR     = 2;
    localparam int CTRL_ONESHOT = 4;
    localparam int CTRL_EN      = 5;
    localparam int CTRL_IE      = 8;

endpackage

// File: rtl/timer_channel.sv
// One prescaled interval timer: prescaler, CNT, LIM, CTRL and terminal-event logic.
// MULTI_TIMER_ONESHOT_EN enables the ONESHOT control bit.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int BITS        = 32,
    parameter int TIME_LENGTH = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wrCnt,
    input  logic            wrLim,
    input  logic            wrCtrl,
    input  logic            rdCnt,
    input  logic [BITS-1:0] dataIn,
    output logic [BITS-1:0] cntValue,
    output logic [BITS-1:0] limValue,
    output logic [BITS-1:0] ctrlValue,
    output logic            irq
);

    localparam int PW = (TIME_LENGTH > 1) ? $clog2(TIME_LENGTH) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TIME_LENGTH - 1);

    logic [PW-1:0]   prescReg, prescNext;
    logic [BITS-1:0] cntReg, cntNext;
    logic [BITS-1:0] limReg, limNext;
    logic            rdyReg, rdyNext;
    logic            ovrReg, ovrNext;
    logic            enReg, enNext;
    logic            ieReg, ieNext;
    logic            irqReg;
    logic            oneShot;
`ifdef MULTI_TIMER_ONESHOT_EN
    logic            oneShotReg, oneShotNext;
    assign oneShot = oneShotReg;
`else
    assign oneShot = 1'b0;
`endif

    logic [BITS-1:0] limLast;
    logic            tick;
    logic            terminal;

    // A CNT or LIM write in the tick cycle supersedes the whole tick, event included.
    assign limLast  = limReg - BITS'(1);
    assign tick     = enReg && (prescReg == PRESC_LAST) && !wrCnt && !wrLim;
    assign terminal = tick && (limReg != '0) && (cntReg == limLast);

    always_comb begin
        prescNext = prescReg;
        cntNext   = cntReg;
        limNext   = limReg;
        rdyNext   = rdyReg;
        ovrNext   = ovrReg;
        enNext    = enReg;
        ieNext    = ieReg;
`ifdef MULTI_TIMER_ONESHOT_EN
        oneShotNext = oneShotReg;
`endif

        if (wrCnt || wrLim) begin
            prescNext = '0;
        end else if (enReg) begin
            prescNext = (prescReg == PRESC_LAST) ? '0 : prescReg + PW'(1);
        end

        // LIM=0 pins the counter at zero, whatever the source of the update.
        if (wrLim) begin
            limNext = dataIn;
            cntNext = '0;
        end else if (wrCnt) begin
            cntNext = ((limReg == '0) || (dataIn > limLast)) ? '0 : dataIn;
        end else if (tick) begin
            cntNext = ((limReg == '0) || (cntReg >= limLast)) ? '0 : cntReg + BITS'(1);
        end

        if (wrCtrl) begin
            enNext = dataIn[CTRL_EN];
            ieNext = dataIn[CTRL_IE];
`ifdef MULTI_TIMER_ONESHOT_EN
            oneShotNext = dataIn[CTRL_ONESHOT];
`endif
            if (!dataIn[CTRL_RDY]) rdyNext = 1'b0;
            if (!dataIn[CTRL_OVR]) ovrNext = 1'b0;
        end

        if (rdCnt) rdyNext = 1'b0;

        // The event is applied last so its set beats any same-cycle clear.
        if (terminal) begin
            rdyNext = 1'b1;
            if (rdyReg) ovrNext = 1'b1;
`ifdef MULTI_TIMER_ONESHOT_EN
            if (oneShotReg) begin
                enNext      = 1'b0;
                oneShotNext = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescReg <= '0;
            cntReg   <= '0;
            limReg   <= '0;
            rdyReg   <= 1'b0;
            ovrReg   <= 1'b0;
            enReg    <= 1'b0;
            ieReg    <= 1'b0;
            irqReg   <= 1'b0;
`ifdef MULTI_TIMER_ONESHOT_EN
            oneShotReg <= 1'b0;
`endif
        end else begin
            prescReg <= prescNext;
            cntReg   <= cntNext;
            limReg   <= limNext;
            rdyReg   <= rdyNext;
            ovrReg   <= ovrNext;
            enReg    <= enNext;
            ieReg    <= ieNext;
            irqReg   <= rdyNext && ieNext;
`ifdef MULTI_TIMER_ONESHOT_EN
            oneShotReg <= oneShotNext;
`endif
        end
    end

    always_comb begin
        ctrlValue               = '0;
        ctrlValue[CTRL_RDY]     = rdyReg;
        ctrlValue[CTRL_OVR]     = ovrReg;
        ctrlValue[CTRL_ONESHOT] = oneShot;
        ctrlValue[CTRL_EN]      = enReg;
        ctrlValue[CTRL_IE]      = ieReg;
    end

    assign cntValue = cntReg;
    assign limValue = limReg;
    assign irq      = irqReg;

endmodule

// File: rtl/multi_timer.sv
// Bank of CHANNELS memory-mapped prescaled interval timers with address decode,
// combinational read mux and interrupt OR. Optional feature: MULTI_TIMER_ONESHOT_EN.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int              BITS        = 32,
    parameter int              CHANNELS    = 4,
    parameter logic [BITS-1:0] BASE        = 32'hF0000100,
    parameter int              TIME_LENGTH = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic                re,
    input  logic [BITS-1:0]     memAddr,
    input  logic [BITS-1:0]     dataBusIn,
    output logic [BITS-1:0]     dataBusOut,
    output logic [CHANNELS-1:0] irq_vec,
    output logic                inta_ready,
    output logic [BITS-1:0]     debug
);

    logic [CHANNELS-1:0] selCnt;
    logic [CHANNELS-1:0] selLim;
    logic [CHANNELS-1:0] selCtrl;
    logic [BITS-1:0]     cntValue  [CHANNELS];
    logic [BITS-1:0]     limValue  [CHANNELS];
    logic [BITS-1:0]     ctrlValue [CHANNELS];

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : gChan
            localparam logic [BITS-1:0] CH_BASE = BASE + BITS'(CHANNEL_STRIDE * gi);

            assign selCnt[gi]  = (memAddr == CH_BASE + BITS'(OFF_CNT));
            assign selLim[gi]  = (memAddr == CH_BASE + BITS'(OFF_LIM));
            assign selCtrl[gi] = (memAddr == CH_BASE + BITS'(OFF_CTRL));

            timer_channel #(
                .BITS        (BITS),
                .TIME_LENGTH (TIME_LENGTH)
            ) uChannel (
                .clk       (clk),
                .reset     (reset),
                .wrCnt     (we && selCnt[gi]),
                .wrLim     (we && selLim[gi]),
                .wrCtrl    (we && selCtrl[gi]),
                .rdCnt     (re && !we && selCnt[gi]),
                .dataIn    (dataBusIn),
                .cntValue  (cntValue[gi]),
                .limValue  (limValue[gi]),
                .ctrlValue (ctrlValue[gi]),
                .irq       (irq_vec[gi])
            );
        end
    endgenerate

    // Selects are one-hot at most, so a priority chain behaves as a plain mux.
    always_comb begin
        dataBusOut = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (selCnt[i])  dataBusOut = cntValue[i];
            if (selLim[i])  dataBusOut = limValue[i];
            if (selCtrl[i]) dataBusOut = ctrlValue[i];
        end
    end

    assign inta_ready = |irq_vec;
    assign debug      = ctrlValue[0];

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus randomized bus traffic
// compared against a cycle-stepped behavioural model of the register rules.
module tb_multi_timer;

    localparam int          NCH  = 4;
    localparam int          TL   = 4;
    localparam logic [31:0] BASE = 32'hF0000100;
`ifdef MULTI_TIMER_ONESHOT_EN
    localparam bit HAS_ONESHOT = 1'b1;
`else
    localparam bit HAS_ONESHOT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset, we, re;
    logic [31:0]    memAddr, dataBusIn, dataBusOut, debug;
    logic [NCH-1:0] irq_vec;
    logic           inta_ready;

    multi_timer #(
        .BITS        (32),
        .CHANNELS    (NCH),
        .BASE        (BASE),
        .TIME_LENGTH (TL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .re         (re),
        .memAddr    (memAddr),
        .dataBusIn  (dataBusIn),
        .dataBusOut (dataBusOut),
        .irq_vec    (irq_vec),
        .inta_ready (inta_ready),
        .debug      (debug)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;

    // Behavioural model of each channel's architectural state.
    logic [31:0] mCnt [NCH];
    logic [31:0] mLim [NCH];
    bit          mRdy [NCH];
    bit          mOvr [NCH];
    bit          mEn  [NCH];
    bit          mIe  [NCH];
    bit          mOne [NCH];
    int          mPh  [NCH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ctrlWord(input int ch);
        return {23'b0, mIe[ch], 2'b0, mEn[ch], mOne[ch], 1'b0, mOvr[ch], 1'b0, mRdy[ch]};
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        for (int ch = 0; ch < NCH; ch++) begin
            if (a == BASE + 32'(16 * ch))     return mCnt[ch];
            if (a == BASE + 32'(16 * ch + 4)) return mLim[ch];
            if (a == BASE + 32'(16 * ch + 8)) return ctrlWord(ch);
        end
        return 32'h0;
    endfunction

    function automatic logic [NCH-1:0] modelIrq();
        logic [NCH-1:0] v;
        for (int ch = 0; ch < NCH; ch++) v[ch] = mRdy[ch] && mIe[ch];
        return v;
    endfunction

    task automatic modelStep(input logic rst, input logic w, input logic r,
                             input logic [31:0] a, input logic [31:0] d);
        for (int ch = 0; ch < NCH; ch++) begin
            logic [31:0] base;
            bit wCnt, wLim, wCtrl, rCnt, tk, ev, oldRdy, oldOne;
            if (rst) begin
                mCnt[ch] = 0; mLim[ch] = 0; mRdy[ch] = 0; mOvr[ch] = 0;
                mEn[ch] = 0; mIe[ch] = 0; mOne[ch] = 0; mPh[ch] = 0;
            end else begin
                base   = BASE + 32'(16 * ch);
                wCnt   = w && (a == base);
                wLim   = w && (a == base + 4);
                wCtrl  = w && (a == base + 8);
                rCnt   = r && !w && (a == base);
                tk     = mEn[ch] && (mPh[ch] == TL - 1) && !wCnt && !wLim;
                ev     = tk && (mLim[ch] != 0) && (mCnt[ch] == mLim[ch] - 1);
                oldRdy = mRdy[ch];
                oldOne = mOne[ch];
                if (wCnt || wLim) mPh[ch] = 0;
                else if (mEn[ch]) mPh[ch] = (mPh[ch] + 1) % TL;
                if (wLim) begin
                    mLim[ch] = d;
                    mCnt[ch] = 0;
                end else if (wCnt) begin
                    mCnt[ch] = (mLim[ch] == 0 || d > mLim[ch] - 1) ? 32'h0 : d;
                end else if (tk) begin
                    mCnt[ch] = (mLim[ch] == 0 || mCnt[ch] >= mLim[ch] - 1) ? 32'h0 : mCnt[ch] + 1;
                end
                if (wCtrl) begin
                    mEn[ch]  = d[5];
                    mIe[ch]  = d[8];
                    mOne[ch] = HAS_ONESHOT && d[4];
                    if (!d[0]) mRdy[ch] = 0;
                    if (!d[2]) mOvr[ch] = 0;
                end
                if (rCnt) mRdy[ch] = 0;
                if (ev) begin
                    mRdy[ch] = 1;
                    if (oldRdy) mOvr[ch] = 1;
                    if (oldOne) begin
                        mEn[ch]  = 0;
                        mOne[ch] = 0;
                    end
                end
            end
        end
    endtask

    // One clock cycle of bus activity; outputs are sampled on the falling edge.
    task automatic busCycle(input logic rst, input logic w, input logic r,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd);
        reset = rst; we = w; re = r; memAddr = a; dataBusIn = d;
        @(negedge clk);
        rd = dataBusOut;
        if (armed) begin
            if (r) check("rdata", dataBusOut, modelRead(a));
            check("irq_vec", 32'(irq_vec), 32'(modelIrq()));
            check("inta_ready", 32'(inta_ready), 32'(|modelIrq()));
            check("debug", debug, ctrlWord(0));
        end
        @(posedge clk);
        modelStep(rst, w, r, a, d);
        #1;
        if (rst || w || r)
            $display("%0t rst=%0b we=%0b re=%0b addr=%h wdata=%h rdata=%h irq=%b",
                     $time, rst, w, r, a, d, rd, irq_vec);
    endtask

    task automatic idle(input int n);
        logic [31:0] rd;
        for (int i = 0; i < n; i++) busCycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rd);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        busCycle(1'b0, 1'b1, 1'b0, a, d, rd);
    endtask

    task automatic rdReg(input logic [31:0] a, output logic [31:0] rd);
        busCycle(1'b0, 1'b0, 1'b1, a, 32'h0, rd);
    endtask

    task automatic readAllZero(input string tag);
        logic [31:0] rd;
        for (int ch = 0; ch < NCH; ch++)
            for (int off = 0; off < 16; off += 4) begin
                rdReg(BASE + 32'(16 * ch + off), rd);
                check(tag, rd, 32'h0);
            end
        check({tag, "_inta"}, 32'(inta_ready), 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] c0, c1, c2, c3;
        reset = 1'b1; we = 1'b0; re = 1'b0; memAddr = '0; dataBusIn = '0;

        for (int i = 0; i < 3; i++) busCycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, rd);
        armed = 1'b1;
        readAllZero("reset");

        c0 = BASE; c1 = BASE + 16; c2 = BASE + 32; c3 = BASE + 48;

        // Channel 0: LIM=3, EN+IE; terminal event 12 cycles after enabling.
        wr(c0 + 4, 32'd3);
        wr(c0 + 8, 32'h120);
        idle(11);
        check("ch0_pre_rdy", debug, 32'h120);
        idle(1);
        check("ch0_rdy", debug, 32'h121);
        check("ch0_irq", 32'(irq_vec[0]), 32'h1);
        rdReg(c0, rd);
        check("ch0_cnt_wrap", rd, 32'h0);
        check("ch0_rdy_clr", debug & 32'h1, 32'h0);
        check("ch0_irq_clr", 32'(irq_vec[0]), 32'h0);

        // Channel 1: two unserviced terminal events raise OVR.
        wr(c1 + 4, 32'd2);
        wr(c1 + 8, 32'h020);
        idle(16);
        rdReg(c1 + 8, rd);
        check("ch1_ovr", rd, 32'h025);
        wr(c1 + 8, 32'h020);
        rdReg(c1 + 8, rd);
        check("ch1_clr", rd, 32'h020);

        // Channel 2: one-shot when built in, periodic otherwise.
        wr(c2 + 4, 32'd5);
        wr(c2 + 8, 32'h130);
        idle(30);
        rdReg(c2 + 8, rd);
        check("ch2_ctrl", rd, HAS_ONESHOT ? 32'h101 : 32'h121);
        if (HAS_ONESHOT) begin
            rdReg(c2, rd);
            check("ch2_frozen", rd, 32'h0);
        end

        // Channel 3: CNT write clamping and LIM write restart.
        wr(c3 + 4, 32'd10);
        wr(c3, 32'd15);
        rdReg(c3, rd);
        check("ch3_clamp", rd, 32'h0);
        wr(c3, 32'd7);
        rdReg(c3, rd);
        check("ch3_load", rd, 32'd7);
        wr(c3 + 8, 32'h020);
        idle(6);
        wr(c3 + 4, 32'd10);
        rdReg(c3, rd);
        check("ch3_lim_restart", rd, 32'h0);

        // Terminal event coinciding with a CNT read keeps RDY set.
        wr(c0 + 4, 32'd3);
        rdReg(c0, rd);
        idle(10);
        rdReg(c0, rd);
        check("coin_read", rd, 32'd2);
        check("coin_rdy", debug & 32'h1, 32'h1);

        // Randomized traffic across all channels.
        for (int k = 0; k < 300; k++) begin
            int          ch;
            int          op;
            logic [31:0] base;
            ch   = $urandom_range(0, NCH - 1);
            op   = $urandom_range(0, 9);
            base = BASE + 32'(16 * ch);
            case (op)
                4, 5: rdReg(base + 32'(4 * $urandom_range(0, 3)), rd);
                6:    wr(base + 4, 32'($urandom_range(1, 6)));
                7:    wr(base, 32'($urandom_range(0, 7)));
                8:    wr(base + 8, $urandom());
                9: begin
                    if ($urandom_range(0, 1) == 0)
                        busCycle(1'b0, 1'b1, 1'b1, base, 32'($urandom_range(0, 7)), rd);
                    else
                        rdReg(BASE + 32'(16 * NCH), rd);
                end
                default: idle(1);
            endcase
        end

        // Reset in the middle of activity wipes everything.
        busCycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, rd);
        readAllZero("midreset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
